// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared constants and state type for the GF(2^M) digit-serial multiplier
//
// Default field: GF(2^16), f(x) = x^16 + x^5 + x^3 + x + 1 (x^16 implicit),
// digit size 4 bits per cycle.
package gf_pkg;

    localparam int          GF_M    = 16;
    localparam int          GF_D    = 4;
    localparam logic [15:0] GF_POLY = 16'h002B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_digit_step.sv
// rtl/gf_digit_step.sv - combinational D-row AND-AND-XOR3 cell array for one digit step
//
// gf_xor3_cell ports:
//   msb_i   top bit of the incoming row value (reduction trigger)
//   poly_i  field polynomial coefficient for this bit
//   digit_i current digit bit of B
//   a_i     operand A bit
//   prev_i  next-lower bit of the incoming row value (0 for bit 0)
//   c_o     row output bit
//
// gf_digit_step ports:
//   c_i      running product entering this step
//   a_i      operand A
//   digit_i  D bits of B, MSB consumed first
//   c_o      c_i * x^D + digit_i * A, reduced mod f
module gf_xor3_cell (
    input  logic msb_i,
    input  logic poly_i,
    input  logic digit_i,
    input  logic a_i,
    input  logic prev_i,
    output logic c_o
);
    assign c_o = (msb_i & poly_i) ^ (digit_i & a_i) ^ prev_i;
endmodule

module gf_digit_step
    import gf_pkg::*;
#(
    parameter int           M    = GF_M,
    parameter int           D    = GF_D,
    parameter logic [M-1:0] POLY = M'(GF_POLY)
) (
    input  logic [M-1:0] c_i,
    input  logic [M-1:0] a_i,
    input  logic [D-1:0] digit_i,
    output logic [M-1:0] c_o
);
    // rows[0] is the input; each row r multiplies by x, reduces, and adds
    // digit bit D-1-r times A, so the digit is consumed MSB first.
    logic [D:0][M-1:0] rows;

    assign rows[0] = c_i;

    for (genvar r = 0; r < D; r++) begin : g_row
        for (genvar i = 0; i < M; i++) begin : g_bit
            logic prev;
            if (i == 0) begin : g_lsb
                assign prev = 1'b0;
            end else begin : g_mid
                assign prev = rows[r][i-1];
            end
            gf_xor3_cell u_cell (
                .msb_i   (rows[r][M-1]),
                .poly_i  (POLY[i]),
                .digit_i (digit_i[D-1-r]),
                .a_i     (a_i[i]),
                .prev_i  (prev),
                .c_o     (rows[r+1][i])
            );
        end
    end

    assign c_o = rows[D];
endmodule

// File: rtl/gf_digit_mac.sv
// rtl/gf_digit_mac.sv - digit-serial GF(2^M) multiplier with valid/ready operand and result ports
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block idle and able to accept operands
//   a, b       operands, polynomial basis (bit i = coefficient of x^i)
//   out_valid  c holds a finished product
//   out_ready  consumer accepts c
//   c          A*B mod f(x); meaningful only while out_valid is high
module gf_digit_mac
    import gf_pkg::*;
#(
    parameter int           M    = GF_M,
    parameter int           D    = GF_D,
    parameter logic [M-1:0] POLY = M'(GF_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c
);
    localparam int            STEPS = M / D;
    localparam int            CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

    if (M % D != 0) begin : g_bad_digit
        $error("gf_digit_mac: M must be a multiple of D");
    end

    gf_state_e     state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  step_c;

    gf_digit_step #(
        .M    (M),
        .D    (D),
        .POLY (POLY)
    ) u_step (
        .c_i     (c_q),
        .a_i     (a_q),
        .digit_i (b_q[M-1 -: D]),
        .c_o     (step_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                c_d = step_c;
                b_d = b_q << D;
                // Counter parks at LAST rather than wrapping.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
endmodule

// File: tb/tb_gf_digit_mac.sv
// tb/tb_gf_digit_mac.sv - scoreboard bench for gf_digit_mac (M=16, D=4, f=0x1002B)
module tb_gf_digit_mac;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;

    logic        out_ready_dir = 1'b1;
    logic        rand_mode = 1'b0;
    logic        rr = 1'b1;
    assign out_ready = rand_mode ? rr : out_ready_dir;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        ov_prev = 1'b0;
    logic [15:0] exp_q[$];

    gf_digit_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rr <= ($urandom_range(0, 9) < 7);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // LSB-first shift-and-add reference, reducing by f = x^16+x^5+x^3+x+1.
    function automatic logic [15:0] gf_ref(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r = '0;
        logic [15:0] s = x;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) r = r ^ s;
            s = s[15] ? ((s << 1) ^ 16'h002B) : (s << 1);
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev) chk("latency", cyc - acc_cyc, LAT);
            if (in_ready && out_valid) chk("ready_valid_exclusive", 1, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", {16'h0, c}, 32'hDEAD_BEEF);
                else chk("result", {16'h0, c}, {16'h0, exp_q.pop_front()});
            end
            ov_prev <= out_valid;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev);
        int n = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(ev);
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    logic [15:0] dir_a[8] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'hFFFF, 16'h8000};
    logic [15:0] dir_b[8] = '{16'h1234, 16'h0002, 16'h0000, 16'hFFFF, 16'h8000, 16'h0003, 16'h0001, 16'h0003};
    logic [15:0] dir_c[8] = '{16'h1234, 16'h002B, 16'h0000, 16'h0000, 16'hC10E, 16'h0101, 16'hFFFF, 16'h802B};

    initial begin
        logic [15:0] held;
        logic [15:0] ra, rb;
        int n;

        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_c", c, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, consumer always ready.
        for (int i = 0; i < 8; i++) send(dir_a[i], dir_b[i], dir_c[i]);
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Backpressure: result held for 10 cycles, new in_valid ignored.
        out_ready_dir = 1'b0;
        send(16'h0002, 16'h0002, 16'h0004);
        wait_valid();
        held = c;
        a = 16'h0003;
        b = 16'h0005;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_c", c, held);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready_dir = 1'b1;
        @(posedge clk);
        #1;
        chk("post_handshake_in_ready", in_ready, 1);
        chk("post_handshake_out_valid", out_valid, 0);
        send(16'h0003, 16'h0005, 16'h000F);
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Reset during BUSY discards the operation.
        send(16'h1234, 16'h5678, 16'h0000);
        void'(exp_q.pop_back());
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_c", c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_valid", n, 0);
        @(posedge clk);
        #1;
        send(16'h8000, 16'h0002, 16'h002B);

        // Random pairs with random gaps and consumer backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, gf_ref(ra, rb));
        end
        repeat (LAT + 1) @(posedge clk);
        rand_mode = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
